// File: rtl/cam_req_sched.sv
// In-order request scheduler in front of the CAM: a small request FIFO, one
// command per cycle, and a single held response slot for read/search results.
module cam_req_sched #(
   parameter int ARRAY_WIDTH_LOG2 = 5,
   parameter int ARRAY_SIZE_LOG2  = 5,
   parameter int FIFO_DEPTH_LOG2  = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               req_valid_i,
   output logic                               req_ready_o,
   input  logic [1:0]                         req_op_i,
   input  logic [ARRAY_WIDTH_LOG2-1:0]        req_index_i,
   input  logic [(2**ARRAY_WIDTH_LOG2)-1:0]   req_data_i,
   output logic                               resp_valid_o,
   input  logic                               resp_ready_i,
   output logic [1:0]                         resp_op_o,
   output logic                               resp_hit_o,
   output logic [ARRAY_WIDTH_LOG2-1:0]        resp_index_o,
   output logic [(2**ARRAY_WIDTH_LOG2)-1:0]   resp_data_o,
   output logic                               cam_read_o,
   output logic                               cam_write_o,
   output logic                               cam_search_o,
   output logic [ARRAY_WIDTH_LOG2-1:0]        cam_read_index_o,
   output logic [ARRAY_WIDTH_LOG2-1:0]        cam_write_index_o,
   output logic [(2**ARRAY_WIDTH_LOG2)-1:0]   cam_write_data_o,
   output logic [(2**ARRAY_WIDTH_LOG2)-1:0]   cam_search_data_o,
   input  logic                               cam_read_valid_i,
   input  logic                               cam_search_valid_i,
   input  logic [(2**ARRAY_WIDTH_LOG2)-1:0]   cam_read_value_i,
   input  logic [ARRAY_WIDTH_LOG2-1:0]        cam_search_index_i
);

   localparam int DW    = 2**ARRAY_WIDTH_LOG2;
   localparam int IW    = ARRAY_WIDTH_LOG2;
   localparam int DEPTH = 2**FIFO_DEPTH_LOG2;
   localparam logic [FIFO_DEPTH_LOG2:0] FULL_COUNT = {1'b1, {FIFO_DEPTH_LOG2{1'b0}}};

   localparam logic [1:0] OP_READ   = 2'b00;
   localparam logic [1:0] OP_WRITE  = 2'b01;
   localparam logic [1:0] OP_SEARCH = 2'b10;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]                 fifo_op    [DEPTH];
   logic [IW-1:0]              fifo_index [DEPTH];
   logic [DW-1:0]              fifo_data  [DEPTH];
   logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_LOG2:0]   count;

   logic [1:0]    state, next_state;
   logic [1:0]    inflight_op;
   logic [IW-1:0] inflight_index;
   logic [1:0]    resp_op_q;
   logic          resp_hit_q;
   logic [IW-1:0] resp_index_q;
   logic [DW-1:0] resp_data_q;

   logic          push, pop, fifo_empty, head_is_rs;
   logic [1:0]    head_op;
   logic [IW-1:0] head_index;
   logic [DW-1:0] head_data;
   logic          unused_size;

   assign unused_size = (ARRAY_SIZE_LOG2 > 0);

   assign req_ready_o = (count != FULL_COUNT);
   assign push        = req_valid_i && req_ready_o;
   assign fifo_empty  = (count == '0);
   assign head_op     = fifo_op[rd_ptr];
   assign head_index  = fifo_index[rd_ptr];
   assign head_data   = fifo_data[rd_ptr];
   assign head_is_rs  = (head_op == OP_READ) || (head_op == OP_SEARCH);

   // Writes and no-ops never wait on the response slot; a read/search may only
   // issue once the slot is empty or being handed off this very cycle.
   always_comb begin
      pop        = 1'b0;
      next_state = state;
      case (state)
         S_IDLE: begin
            if (!fifo_empty) begin
               pop = 1'b1;
               if (head_is_rs) next_state = S_WAIT;
            end
         end
         S_WAIT: next_state = S_RESP;
         S_RESP: begin
            if (!fifo_empty && !head_is_rs) pop = 1'b1;
            if (resp_ready_i) begin
               if (!fifo_empty && head_is_rs) begin
                  pop        = 1'b1;
                  next_state = S_WAIT;
               end else begin
                  next_state = S_IDLE;
               end
            end
         end
         default: next_state = S_IDLE;
      endcase
   end

   assign cam_read_o        = pop && (head_op == OP_READ);
   assign cam_write_o       = pop && (head_op == OP_WRITE);
   assign cam_search_o      = pop && (head_op == OP_SEARCH);
   assign cam_read_index_o  = cam_read_o   ? head_index : '0;
   assign cam_write_index_o = cam_write_o  ? head_index : '0;
   assign cam_write_data_o  = cam_write_o  ? head_data  : '0;
   assign cam_search_data_o = cam_search_o ? head_data  : '0;

   assign resp_valid_o = (state == S_RESP);
   assign resp_op_o    = resp_valid_o ? resp_op_q    : '0;
   assign resp_hit_o   = resp_valid_o && resp_hit_q;
   assign resp_index_o = resp_valid_o ? resp_index_q : '0;
   assign resp_data_o  = resp_valid_o ? resp_data_q  : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr]    <= req_op_i;
         fifo_index[wr_ptr] <= req_index_i;
         fifo_data[wr_ptr]  <= req_data_i;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // The CAM answers one cycle after the strobe, so the WAIT cycle is when its
   // outputs are sampled; the read index comes from the request, not the CAM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= S_IDLE;
         inflight_op    <= '0;
         inflight_index <= '0;
         resp_op_q      <= '0;
         resp_hit_q     <= 1'b0;
         resp_index_q   <= '0;
         resp_data_q    <= '0;
      end else begin
         state <= next_state;
         if (pop && head_is_rs) begin
            inflight_op    <= head_op;
            inflight_index <= head_index;
         end
         if (state == S_WAIT) begin
            resp_op_q <= inflight_op;
            if (inflight_op == OP_READ) begin
               resp_hit_q   <= cam_read_valid_i;
               resp_index_q <= inflight_index;
               resp_data_q  <= cam_read_value_i;
            end else begin
               resp_hit_q   <= cam_search_valid_i;
               resp_index_q <= cam_search_valid_i ? cam_search_index_i : '0;
               resp_data_q  <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cam_req_sched.sv
// Directed bench for cam_req_sched with a behavioural CAM answering its strobes.
module tb_cam_req_sched;

   localparam logic [1:0] RD = 2'b00, WR = 2'b01, SR = 2'b10, NOP = 2'b11;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, resp_valid, resp_ready;
   logic [1:0]  req_op, resp_op;
   logic [4:0]  req_index, resp_index;
   logic [31:0] req_data, resp_data;
   logic        resp_hit;
   logic        cam_read, cam_write, cam_search;
   logic [4:0]  cam_read_index, cam_write_index, cam_search_index;
   logic [31:0] cam_write_data, cam_search_data, cam_read_value;
   logic        cam_read_valid, cam_search_valid;

   int errors = 0;
   int checks = 0;
   int resp_count = 0;
   int resp_base;

   logic [31:0] mem  [32];
   logic        mval [32];
   logic        found;
   logic [4:0]  fidx;

   always #5 clk = ~clk;

   cam_req_sched dut (
      .clk(clk), .reset(reset),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
      .req_index_i(req_index), .req_data_i(req_data),
      .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_op_o(resp_op),
      .resp_hit_o(resp_hit), .resp_index_o(resp_index), .resp_data_o(resp_data),
      .cam_read_o(cam_read), .cam_write_o(cam_write), .cam_search_o(cam_search),
      .cam_read_index_o(cam_read_index), .cam_write_index_o(cam_write_index),
      .cam_write_data_o(cam_write_data), .cam_search_data_o(cam_search_data),
      .cam_read_valid_i(cam_read_valid), .cam_search_valid_i(cam_search_valid),
      .cam_read_value_i(cam_read_value), .cam_search_index_i(cam_search_index)
   );

   // Behavioural CAM: writes land on the edge, read/search answer one cycle later,
   // search reports the lowest matching valid entry.
   initial begin
      for (int i = 0; i < 32; i++) begin
         mem[i]  = '0;
         mval[i] = 1'b0;
      end
      cam_read_valid   = 1'b0;
      cam_read_value   = '0;
      cam_search_valid = 1'b0;
      cam_search_index = '0;
   end

   always @(posedge clk) begin
      found = 1'b0;
      fidx  = '0;
      for (int i = 31; i >= 0; i--) begin
         if (mval[i] && mem[i] == cam_search_data) begin
            found = 1'b1;
            fidx  = i[4:0];
         end
      end
      cam_read_valid   <= cam_read && mval[cam_read_index];
      cam_read_value   <= cam_read ? mem[cam_read_index] : 32'h0;
      cam_search_valid <= cam_search && found;
      cam_search_index <= (cam_search && found) ? fidx : 5'd0;
      if (cam_write) begin
         mem[cam_write_index]  <= cam_write_data;
         mval[cam_write_index] <= 1'b1;
      end
   end

   always @(posedge clk) begin
      if (resp_valid && resp_ready) resp_count <= resp_count + 1;
   end

   task automatic applyStimulus(input logic v, input logic [1:0] op, input logic [4:0] idx,
                                input logic [31:0] data, input logic rdy);
      @(negedge clk);
      req_valid  = v;
      req_op     = op;
      req_index  = idx;
      req_data   = data;
      resp_ready = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAllIdle(input string tag);
      checkOutput({tag, "_ready"},  {31'b0, req_ready}, 32'd1);
      checkOutput({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd0);
      checkOutput({tag, "_rop"},    {30'b0, resp_op}, 32'd0);
      checkOutput({tag, "_rhit"},   {31'b0, resp_hit}, 32'd0);
      checkOutput({tag, "_ridx"},   {27'b0, resp_index}, 32'd0);
      checkOutput({tag, "_rdata"},  resp_data, 32'd0);
      checkOutput({tag, "_strobes"}, {29'b0, cam_read, cam_write, cam_search}, 32'd0);
      checkOutput({tag, "_camidx"}, {22'b0, cam_read_index, cam_write_index}, 32'd0);
      checkOutput({tag, "_camwd"},  cam_write_data, 32'd0);
      checkOutput({tag, "_camsd"},  cam_search_data, 32'd0);
   endtask

   logic [4:0]  exp_idx  [4] = '{5'd7, 5'd0, 5'd3, 5'd7};
   logic [31:0] exp_data [4] = '{32'h12345678, 32'h0, 32'hDEADBEEF, 32'h12345678};
   logic        exp_hit  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   logic [4:0]  nxt_idx  [4] = '{5'd0, 5'd3, 5'd7, 5'd0};

   initial begin
      reset = 1'b1;
      req_valid = 1'b0; req_op = NOP; req_index = '0; req_data = '0; resp_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkAllIdle("reset");
      @(negedge clk);
      reset = 1'b0;

      // Write idx 3 then read it back
      applyStimulus(1, WR, 5'd3, 32'hDEADBEEF, 0);
      checkOutput("w_not_same_cycle", {31'b0, cam_write}, 32'd0);
      applyStimulus(1, RD, 5'd3, 32'h0, 0);
      checkOutput("w_strobe", {31'b0, cam_write}, 32'd1);
      checkOutput("w_index", {27'b0, cam_write_index}, 32'd3);
      checkOutput("w_data", cam_write_data, 32'hDEADBEEF);
      checkOutput("w_no_read", {31'b0, cam_read}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("r_strobe", {31'b0, cam_read}, 32'd1);
      checkOutput("r_index", {27'b0, cam_read_index}, 32'd3);
      checkOutput("r_wdata_zero", cam_write_data, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("r_wait_novalid", {31'b0, resp_valid}, 32'd0);
      checkOutput("r_wait_nostrobe", {31'b0, cam_read}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("r_resp_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("r_resp_op", {30'b0, resp_op}, 32'd0);
      checkOutput("r_resp_hit", {31'b0, resp_hit}, 32'd1);
      checkOutput("r_resp_idx", {27'b0, resp_index}, 32'd3);
      checkOutput("r_resp_data", resp_data, 32'hDEADBEEF);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("r_consumed", {31'b0, resp_valid}, 32'd0);

      // Search hit and miss
      applyStimulus(1, WR, 5'd7, 32'h12345678, 0);
      applyStimulus(1, SR, 5'd0, 32'h12345678, 0);
      checkOutput("s_write_idx", {27'b0, cam_write_index}, 32'd7);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("s_strobe", {31'b0, cam_search}, 32'd1);
      checkOutput("s_key", cam_search_data, 32'h12345678);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("s_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("s_op", {30'b0, resp_op}, 32'd2);
      checkOutput("s_hit", {31'b0, resp_hit}, 32'd1);
      checkOutput("s_idx", {27'b0, resp_index}, 32'd7);
      checkOutput("s_data", resp_data, 32'd0);
      applyStimulus(1, SR, 5'd0, 32'hCAFEF00D, 0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("sm_strobe", {31'b0, cam_search}, 32'd1);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("sm_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("sm_op", {30'b0, resp_op}, 32'd2);
      checkOutput("sm_hit", {31'b0, resp_hit}, 32'd0);
      checkOutput("sm_idx", {27'b0, resp_index}, 32'd0);

      // Fill the FIFO behind a stalled response, then drain in order
      applyStimulus(1, RD, 5'd3, 32'h0, 0);
      checkOutput("f_ready0", {31'b0, req_ready}, 32'd1);
      applyStimulus(1, RD, 5'd7, 32'h0, 0);
      checkOutput("f_issue1", {27'b0, cam_read_index}, 32'd3);
      applyStimulus(1, RD, 5'd0, 32'h0, 0);
      applyStimulus(1, RD, 5'd3, 32'h0, 0);
      checkOutput("f_stall_noissue", {31'b0, cam_read}, 32'd0);
      applyStimulus(1, RD, 5'd7, 32'h0, 0);
      checkOutput("f_ready_before_full", {31'b0, req_ready}, 32'd1);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("f_full", {31'b0, req_ready}, 32'd0);
      checkOutput("f_hold_idx", {27'b0, resp_index}, 32'd3);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("f_hold_valid", {31'b0, resp_valid}, 32'd1);
      checkOutput("f_hold_data", resp_data, 32'hDEADBEEF);
      checkOutput("f_hold_noissue", {31'b0, cam_read}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("f_handoff_issue", {31'b0, cam_read}, 32'd1);
      checkOutput("f_handoff_idx", {27'b0, cam_read_index}, 32'd7);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, NOP, 5'd0, 32'h0, 1);
         checkOutput($sformatf("f_wait%0d", i), {31'b0, resp_valid}, 32'd0);
         checkOutput($sformatf("f_ready%0d", i), {31'b0, req_ready}, 32'd1);
         applyStimulus(0, NOP, 5'd0, 32'h0, 1);
         checkOutput($sformatf("f_valid%0d", i), {31'b0, resp_valid}, 32'd1);
         checkOutput($sformatf("f_idx%0d", i), {27'b0, resp_index}, {27'b0, exp_idx[i]});
         checkOutput($sformatf("f_data%0d", i), resp_data, exp_data[i]);
         checkOutput($sformatf("f_hit%0d", i), {31'b0, resp_hit}, {31'b0, exp_hit[i]});
         if (i < 3)
            checkOutput($sformatf("f_next%0d", i), {26'b0, cam_read, cam_read_index},
                        {26'b0, 1'b1, nxt_idx[i]});
      end
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("f_drained", {31'b0, resp_valid}, 32'd0);

      // Write queued behind a stalled read must not overtake it
      applyStimulus(1, RD, 5'd7, 32'h0, 0);
      applyStimulus(1, RD, 5'd3, 32'h0, 0);
      checkOutput("o_issueA", {26'b0, cam_read, cam_read_index}, {26'b0, 1'b1, 5'd7});
      applyStimulus(1, WR, 5'd3, 32'h55AA55AA, 0);
      checkOutput("o_nowrite0", {31'b0, cam_write}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("o_slotA", {27'b0, resp_index}, 32'd7);
      checkOutput("o_nowrite1", {30'b0, cam_write, cam_read}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("o_nowrite2", {31'b0, cam_write}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("o_issueB", {26'b0, cam_read, cam_read_index}, {26'b0, 1'b1, 5'd3});
      checkOutput("o_nowrite3", {31'b0, cam_write}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("o_nowrite4", {31'b0, cam_write}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("o_B_olddata", resp_data, 32'hDEADBEEF);
      checkOutput("o_write_now", {31'b0, cam_write}, 32'd1);
      checkOutput("o_write_data", cam_write_data, 32'h55AA55AA);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      checkOutput("o_done", {30'b0, resp_valid, cam_write}, 32'd0);
      resp_base = resp_count;

      // No-op between two reads
      applyStimulus(1, RD, 5'd3, 32'h0, 1);
      applyStimulus(1, NOP, 5'd0, 32'h0, 1);
      checkOutput("n_issue1", {31'b0, cam_read}, 32'd1);
      applyStimulus(1, RD, 5'd7, 32'h0, 1);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("n_resp1", resp_data, 32'h55AA55AA);
      checkOutput("n_nop_nostrobe", {29'b0, cam_read, cam_write, cam_search}, 32'd0);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("n_issue2", {26'b0, cam_read, cam_read_index}, {26'b0, 1'b1, 5'd7});
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("n_resp2", resp_data, 32'h12345678);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      applyStimulus(0, NOP, 5'd0, 32'h0, 1);
      checkOutput("n_quiet", {31'b0, resp_valid}, 32'd0);
      checkOutput("n_resp_count", resp_count - resp_base, 32'd2);

      // Reset while a read is in flight and another is queued
      applyStimulus(1, RD, 5'd3, 32'h0, 0);
      applyStimulus(1, RD, 5'd7, 32'h0, 0);
      checkOutput("x_issued", {31'b0, cam_read}, 32'd1);
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      reset = 1'b1;
      #1;
      checkAllIdle("x_reset");
      applyStimulus(0, NOP, 5'd0, 32'h0, 0);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, NOP, 5'd0, 32'h0, 0);
         checkOutput($sformatf("x_after%0d", i), {30'b0, resp_valid, cam_read}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #20000;
      $display("[TB] FAIL timeout: observed=running expected=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
